// File: rtl/alu_rv_stage.sv
// alu_rv_stage: 8-op ALU behind a ready-valid input, results buffered in a 2-entry FIFO.
// o_READY is registered from the next occupancy, so backpressure never reaches the input combinationally.
module alu_rv_stage #(
    parameter int WIDTH = 8
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_VALID,
    output logic                 o_READY,
    input  logic [2*WIDTH+2:0]   i_D,
    output logic                 o_VALID,
    input  logic                 i_READY,
    output logic [WIDTH+1:0]     o_Y
);
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   cr;
    logic [WIDTH+1:0] res;
    logic [WIDTH+1:0] mem [2];
    logic             head, push, pop;
    logic [1:0]       count, cnt_nxt;

    assign {op, a, b} = i_D;

    // cr = {carry, result}; the extra top bit of the subtraction is the borrow
    always_comb begin
        cr = '0;
        case (op)
            3'd0: cr = {1'b0, a} + {1'b0, b};
            3'd1: cr = {1'b0, a} - {1'b0, b};
            3'd2: cr = {1'b0, a & b};
            3'd3: cr = {1'b0, a | b};
            3'd4: cr = {1'b0, a ^ b};
            3'd5: cr = {1'b0, ~a};
            3'd6: cr = {a, 1'b0};
            3'd7: cr = {a[0], 1'b0, a[WIDTH-1:1]};
        endcase
    end

    assign res     = {cr[WIDTH-1:0] == '0, cr};
    assign push    = i_VALID & o_READY;
    assign pop     = o_VALID & i_READY;
    assign cnt_nxt = count + {1'b0, push} - {1'b0, pop};
    assign o_VALID = count != 2'd0;
    assign o_Y     = mem[head];

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            count   <= '0;
            head    <= 1'b0;
            o_READY <= 1'b0;
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else begin
            count   <= cnt_nxt;
            o_READY <= cnt_nxt != 2'd2;
            if (push) mem[head ^ count[0]] <= res;
            if (pop) head <= ~head;
        end
    end
endmodule

// File: tb/tb_alu_rv_stage.sv
// tb_alu_rv_stage: directed vector table, backpressure/streaming/reset sequences, seeded random with scoreboard.
module tb_alu_rv_stage;
    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [18:0] d;
    logic [9:0]  y;
    int          total = 0;
    int          bad = 0;
    logic [9:0]  sb [$];

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [9:0] y;
    } vec_t;
    vec_t vt [12];

    alu_rv_stage #(.WIDTH(8)) dut (
        .i_CLK(clk), .i_RST(rst), .i_VALID(in_valid), .o_READY(out_ready),
        .i_D(d), .o_VALID(out_valid), .i_READY(in_ready), .o_Y(y)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    function automatic logic [9:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, r;
        logic c;
        ua = a;
        ub = b;
        c = 0;
        case (op)
            0: begin r = ua + ub; c = r > 255; end
            1: begin r = ua - ub; c = ua < ub; end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: r = 255 - ua;
            6: begin r = ua * 2; c = ua >= 128; end
            default: begin r = ua / 2; c = ua % 2 == 1; end
        endcase
        r = r & 255;
        return {r == 0, c, r[7:0]};
    endfunction

    initial begin
        vt[0]  = '{3'd0, 8'hFF, 8'h01, 10'h300};
        vt[1]  = '{3'd1, 8'h05, 8'h07, 10'h1FE};
        vt[2]  = '{3'd7, 8'h01, 8'h00, 10'h300};
        vt[3]  = '{3'd6, 8'h81, 8'h00, 10'h102};
        vt[4]  = '{3'd5, 8'hFF, 8'h00, 10'h200};
        vt[5]  = '{3'd4, 8'h5A, 8'h0F, 10'h055};
        vt[6]  = '{3'd2, 8'hF0, 8'h3C, 10'h030};
        vt[7]  = '{3'd3, 8'h00, 8'h00, 10'h200};
        vt[8]  = '{3'd1, 8'h07, 8'h07, 10'h200};
        vt[9]  = '{3'd0, 8'h10, 8'h20, 10'h030};
        vt[10] = '{3'd6, 8'h40, 8'h00, 10'h080};
        vt[11] = '{3'd7, 8'h02, 8'hAA, 10'h001};
        void'($urandom(32'h2468ACE1));
        in_valid = 0;
        in_ready = 1;
        d = '0;
        rst = 0;
        #1 rst = 1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", out_ready, 0);
        chk("rst_y", y, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", out_ready, 1);
        chk("post_rst_valid", out_valid, 0);

        // table: one word at a time, sink always ready
        for (int i = 0; i < 12; i++) begin
            in_valid = 1;
            d = {vt[i].op, vt[i].a, vt[i].b};
            @(posedge clk);
            #1;
            in_valid = 0;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_y", i), y, vt[i].y);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_drain", i), out_valid, 0);
        end

        // backpressure: two accepted, third held until the sink frees a slot
        in_ready = 0;
        in_valid = 1;
        d = {3'd0, 8'd0, 8'd1};
        @(posedge clk);
        #1;
        chk("bp1_y", y, 10'h001);
        chk("bp1_ready", out_ready, 1);
        d = {3'd0, 8'd1, 8'd1};
        @(posedge clk);
        #1;
        chk("bp2_ready", out_ready, 0);
        chk("bp2_y", y, 10'h001);
        d = {3'd0, 8'd1, 8'd2};
        @(posedge clk);
        #1;
        chk("bp3_ready", out_ready, 0);
        chk("bp3_y", y, 10'h001);
        chk("bp3_valid", out_valid, 1);
        in_ready = 1;
        @(posedge clk);
        #1;
        chk("bp4_y", y, 10'h002);
        chk("bp4_ready", out_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("bp5_y", y, 10'h003);
        chk("bp5_valid", out_valid, 1);
        @(posedge clk);
        #1;
        chk("bp6_valid", out_valid, 0);

        // streaming at full rate
        for (int i = 0; i < 20; i++) begin
            in_valid = 1;
            d = {3'd0, 8'(i * 13), 8'd1};
            @(posedge clk);
            #1;
            chk($sformatf("str%0d_y", i), y, ref_alu(3'd0, 8'(i * 13), 8'd1));
            chk($sformatf("str%0d_ready", i), out_ready, 1);
        end
        in_valid = 0;
        @(posedge clk);
        #1;
        chk("str_drain", out_valid, 0);

        // reset with a full queue, asserted between edges
        in_ready = 0;
        in_valid = 1;
        d = {3'd3, 8'h11, 8'h22};
        @(posedge clk);
        #1;
        d = {3'd3, 8'h44, 8'h08};
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("full_ready", out_ready, 0);
        #3 rst = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", out_ready, 0);
        chk("mid_rst_y", y, 0);
        @(posedge clk);
        #1 rst = 0;
        in_ready = 1;
        @(posedge clk);
        #1;
        chk("mid_post_ready", out_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid_stale%0d", i), out_valid, 0);
            @(posedge clk);
            #1;
        end

        // random source/sink against a scoreboard
        for (int i = 0; i < 126; i++) begin
            in_valid = (i < 120) ? 1'($urandom % 2) : 1'b0;
            in_ready = (i < 120) ? 1'($urandom % 2) : 1'b1;
            d = 19'($urandom);
            #1;
            chk($sformatf("rnd%0d_valid", i), out_valid, sb.size() != 0);
            if (out_valid && in_ready && sb.size() != 0) chk($sformatf("rnd%0d_y", i), y, sb.pop_front());
            if (in_valid && out_ready) sb.push_back(ref_alu(d[18:16], d[15:8], d[7:0]));
            @(posedge clk);
            #1;
        end
        chk("rnd_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_rv_stage.md
# alu_rv_stage

Synthesizable ALU stage with READY-VALID handshakes on both sides; it is the design-under-test that sits between the bench's random READY-VALID source and its READY-VALID sink. It accepts packed operation words, computes an 8-operation ALU result with carry and zero flags, and buffers up to two results in a 2-entry output queue. The queue absorbs sink backpressure without a combinational READY path from output to input.

## Interface
- WIDTH, 8, operand and result width (>= 2)
- i_CLK  input  1  clock, all state updates on rising edge
- i_RST  input  1  reset, asynchronous, active-high
- i_VALID  input  1  upstream word valid
- o_READY  output  1  stage can accept a word (registered)
- i_D  input  2*WIDTH+3  {op[2:0], A[WIDTH-1:0], B[WIDTH-1:0]}, op in MSBs
- o_VALID  output  1  result at head of queue valid
- i_READY  input  1  downstream accepts result
- o_Y  output  WIDTH+2  {Z, C, R[WIDTH-1:0]}, Z in MSB

## Operation
- Input transfer: rising edge with i_VALID=1 and o_READY=1; word computed and written to queue tail at that edge.
- Output transfer: rising edge with o_VALID=1 and i_READY=1; head popped at that edge.
- Ops, all arithmetic mod 2^WIDTH for R:
  - 000 ADD: {C,R} = A+B (C = carry out)
  - 001 SUB: R = A-B, C = 1 iff A<B (borrow)
  - 010 AND, 011 OR, 100 XOR: bitwise, C=0
  - 101 NOT: R = ~A, B ignored, C=0
  - 110 SHL: R = A<<1, C = A[WIDTH-1]
  - 111 SHR: R = A>>1 logical, C = A[0]
- Z = 1 iff R == 0, for every op.
- Queue: 2 entries, strict FIFO order, occupancy count 0..2.
  - push only: count+1; pop only: count-1; push and pop together: count unchanged, head advances, new word at tail.
  - count 0 with push: word appears at head next cycle.
- o_READY register: next value = (next count < 2). It is low while full; a pop at a full edge raises it for the following cycle.
- o_VALID = (count != 0); o_Y = head entry.
- No data is dropped and none is duplicated. i_D is sampled only on an input transfer.

## Timing
- Reset (i_RST=1, asynchronous): count=0, o_VALID=0, o_READY=0; o_Y=0. The effect is immediate, without waiting for a clock edge.
- First rising edge after i_RST falls: o_READY -> 1; o_VALID stays 0.
- Latency: a word accepted at edge k is visible on o_Y/o_VALID after edge k, and can be popped at edge k+1 at the earliest.
- Throughput: 1 word/cycle sustained when i_READY=1 continuously.
- Stall stability: while o_VALID=1 and i_READY=0, o_Y and o_VALID hold unchanged.
- o_READY depends only on registers, so there is no combinational path from i_READY or i_VALID to o_READY.
- Upstream may change i_D/i_VALID freely when o_READY=0; nothing is captured.
- Reset mid-operation: queued results are discarded, and the block restarts as after a fresh reset.

## Test plan
- Reset: hold i_RST=1 for 3 cycles, then release -> o_VALID=0, o_READY=0 and o_Y=0 during reset; o_READY=1 after the first edge post-release. Assert i_RST asynchronously between edges -> outputs clear before the next edge.
- Arithmetic (WIDTH=8), with i_READY=1:
  - ADD A=0xFF, B=0x01 -> o_Y=0x300
  - SUB A=0x05, B=0x07 -> o_Y=0x1FE
  - SHR A=0x01 -> o_Y=0x300
  - SHL A=0x81 -> o_Y=0x102
  - NOT A=0xFF -> o_Y=0x200
  - XOR A=0x5A, B=0x0F -> o_Y=0x055
- Backpressure: set i_READY=0 and offer 3 ADD words (results 0x001, 0x002, 0x003) -> the first two are accepted; o_READY=0 after the second acceptance; the third is held. o_Y stays 0x001. Then set i_READY=1 -> outputs 0x001, 0x002, 0x003 in order, and o_READY returns to 1.
- Streaming: i_VALID=1 and i_READY=1 for 20 cycles with incrementing A -> one result per cycle, o_READY constantly 1, count never exceeds 1.
- Reset mid-operation: with the queue full (2 entries), pulse i_RST for one cycle -> o_VALID=0 immediately. After release, neither stale result appears.
- Random: bench source and sink drive i_VALID/i_READY from a seeded PRNG for 120 cycles, with an independent scoreboard model -> every accepted word produces exactly one matching o_Y, in order, with zero mismatches.
